// File: rtl/dds_phase_gen.sv
// Phase-accumulator front end for the DDS datapath: integrates a tuning word, emits the
// lookup phase address, and runs a saturating upward chirp. Config loads commit at the wrap.
module dds_phase_gen #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 11,
  parameter int LUT_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              enable,
  input  logic              sweep_start,
  input  logic              sweep_stop,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              wrap,
  output logic              valid_aligned,
  output logic              wrap_aligned,
  output logic              sweep_done
);

  typedef enum logic [1:0] {IDLE, SWEEP, HOLD} sweep_state_t;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_OFF  = 2'd1;
  localparam logic [1:0] SEL_STEP = 2'd2;
  localparam logic [1:0] SEL_END  = 2'd3;

  logic [ACC_W-1:0]   ftw_base, phase_off, sweep_step, ftw_end;
  logic [ACC_W-1:0]   shadow_data, ftw_cur, acc;
  logic [1:0]         shadow_sel;
  logic               pending, carry_q;
  logic [LUT_LAT-1:0] valid_pipe, wrap_pipe;
  sweep_state_t       state;

  logic [ACC_W:0]     acc_sum, sweep_sum;
  logic [ADDR_W-1:0]  addr_next;
  logic               carry, commit, accept, base_commit, sweep_at_end;

  always_comb begin
    acc_sum      = {1'b0, acc} + {1'b0, ftw_cur};
    carry        = enable && acc_sum[ACC_W];
    commit       = pending && (!enable || carry);
    accept       = cfg_valid && !pending;
    base_commit  = commit && (shadow_sel == SEL_BASE);
    addr_next    = ADDR_W'((acc + phase_off) >> (ACC_W - ADDR_W));
    // Chirp sum is one bit wider so a huge step saturates at ftw_end instead of wrapping.
    sweep_sum    = {1'b0, ftw_cur} + {1'b0, sweep_step};
    sweep_at_end = sweep_sum >= {1'b0, ftw_end};
  end

  assign cfg_ready     = !pending;
  assign valid_aligned = valid_pipe[LUT_LAT-1];
  assign wrap_aligned  = wrap_pipe[LUT_LAT-1];

  // Config port: one shadow slot, transferred to the active set at a wrap or while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ftw_base    <= '0;
      phase_off   <= '0;
      sweep_step  <= '0;
      ftw_end     <= '0;
      shadow_data <= '0;
      shadow_sel  <= SEL_BASE;
      pending     <= 1'b0;
    end else if (commit) begin
      pending <= 1'b0;
      case (shadow_sel)
        SEL_BASE: ftw_base   <= shadow_data;
        SEL_OFF:  phase_off  <= shadow_data;
        SEL_STEP: sweep_step <= shadow_data;
        SEL_END:  ftw_end    <= shadow_data;
      endcase
    end else if (accept) begin
      shadow_data <= cfg_data;
      shadow_sel  <= cfg_sel;
      pending     <= 1'b1;
    end
  end

  // Accumulator and address stage; carry_q holds across disabled cycles so the
  // wrap flag lands on the first live sample taken from the post-overflow value.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      carry_q    <= 1'b0;
      addr       <= '0;
      addr_valid <= 1'b0;
      wrap       <= 1'b0;
      valid_pipe <= '0;
      wrap_pipe  <= '0;
    end else begin
      if (enable) begin
        acc        <= acc_sum[ACC_W-1:0];
        carry_q    <= acc_sum[ACC_W];
        addr       <= addr_next;
        addr_valid <= 1'b1;
        wrap       <= carry_q;
      end else begin
        addr_valid <= 1'b0;
        wrap       <= 1'b0;
      end
      valid_pipe <= {valid_pipe[LUT_LAT-2:0], addr_valid};
      wrap_pipe  <= {wrap_pipe[LUT_LAT-2:0], wrap};
    end
  end

  // Sweep FSM owns ftw_cur.
  // NOTE: nonblocking updates mean this block sees ftw_base/sweep_step/ftw_end as they
  // were before a same-cycle commit; a commit coinciding with an increment applies next carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ftw_cur    <= '0;
      sweep_done <= 1'b0;
    end else begin
      // NOTE: pulse defaults low every cycle; only the HOLD-entry paths raise it.
      sweep_done <= 1'b0;
      if (sweep_stop) begin
        state   <= IDLE;
        ftw_cur <= ftw_base;
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (sweep_start) begin
              if (ftw_base >= ftw_end) begin
                ftw_cur    <= ftw_end;
                state      <= HOLD;
                sweep_done <= 1'b1;
              end else begin
                ftw_cur <= ftw_base;
                state   <= SWEEP;
              end
            end else if (state == IDLE) begin
              ftw_cur <= base_commit ? shadow_data : ftw_base;
            end
          end
          SWEEP: begin
            if (carry) begin
              if (sweep_at_end) begin
                ftw_cur    <= ftw_end;
                state      <= HOLD;
                sweep_done <= 1'b1;
              end else begin
                ftw_cur <= sweep_sum[ACC_W-1:0];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the phase generator.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_sel = 2'd0;
  logic [31:0] cfg_data = 32'd0;
  logic        enable = 1'b0;
  logic        sweep_start = 1'b0;
  logic        sweep_stop = 1'b0;
  logic [10:0] addr;
  logic        addr_valid, wrap, valid_aligned, wrap_aligned, sweep_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_phase_gen #(.ACC_W(32), .ADDR_W(11), .LUT_LAT(3)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .enable(enable),
    .sweep_start(sweep_start), .sweep_stop(sweep_stop), .addr(addr),
    .addr_valid(addr_valid), .wrap(wrap), .valid_aligned(valid_aligned),
    .wrap_aligned(wrap_aligned), .sweep_done(sweep_done)
  );

  // Behavioural model: phase as a 33-bit sum, strobe delays as queues.
  typedef enum {M_IDLE, M_SWEEP, M_HOLD} mode_t;
  logic [31:0] m_acc = 0, m_cur = 0, m_base = 0, m_off = 0, m_step = 0, m_end = 0, m_sh_data = 0;
  logic [1:0]  m_sh_sel = 0;
  logic [10:0] m_addr = 0;
  bit          m_pend = 0, m_ovf = 0, m_valid = 0, m_wrap = 0, m_done = 0, m_va = 0, m_wa = 0;
  mode_t       m_mode = M_IDLE;
  bit          vhist[$];
  bit          whist[$];

  always @(posedge clk) begin : ref_model
    logic [32:0] total, raised;
    logic [31:0] phase, base0, end0, step0;
    bit ov, cm;
    if (rst) begin
      m_acc = 0; m_cur = 0; m_base = 0; m_off = 0; m_step = 0; m_end = 0;
      m_sh_data = 0; m_sh_sel = 0; m_addr = 0; m_pend = 0; m_ovf = 0;
      m_valid = 0; m_wrap = 0; m_done = 0; m_va = 0; m_wa = 0; m_mode = M_IDLE;
      vhist.delete(); whist.delete();
      repeat (3) begin vhist.push_back(1'b0); whist.push_back(1'b0); end
    end else begin
      base0 = m_base; end0 = m_end; step0 = m_step;
      total = {1'b0, m_acc} + {1'b0, m_cur};
      ov = enable && total[32];
      cm = m_pend && (!enable || ov);
      m_done = 0;
      if (enable) begin
        phase   = m_acc + m_off;
        m_addr  = phase[31:21];
        m_wrap  = m_ovf;
        m_valid = 1;
        m_ovf   = total[32];
        m_acc   = total[31:0];
      end else begin
        m_valid = 0;
        m_wrap  = 0;
      end
      vhist.push_back(m_valid); m_va = vhist.pop_front();
      whist.push_back(m_wrap);  m_wa = whist.pop_front();
      if (sweep_stop) begin
        m_mode = M_IDLE; m_cur = base0;
      end else if (sweep_start && m_mode != M_SWEEP) begin
        if (base0 >= end0) begin m_cur = end0; m_mode = M_HOLD; m_done = 1; end
        else begin m_cur = base0; m_mode = M_SWEEP; end
      end else if (m_mode == M_IDLE) begin
        m_cur = (cm && m_sh_sel == 2'd0) ? m_sh_data : base0;
      end else if (m_mode == M_SWEEP && ov) begin
        raised = {1'b0, m_cur} + {1'b0, step0};
        if (raised >= {1'b0, end0}) begin m_cur = end0; m_mode = M_HOLD; m_done = 1; end
        else m_cur = raised[31:0];
      end
      if (cm) begin
        m_pend = 0;
        case (m_sh_sel)
          2'd0: m_base = m_sh_data;
          2'd1: m_off  = m_sh_data;
          2'd2: m_step = m_sh_data;
          default: m_end = m_sh_data;
        endcase
      end else if (cfg_valid && !m_pend) begin
        m_sh_sel = cfg_sel; m_sh_data = cfg_data; m_pend = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enable = 0; cfg_valid = 0; sweep_start = 0; sweep_stop = 0; rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
    int n = 0;
    while (!cfg_ready && n < 5000) begin tick(); n++; end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL cfg_write_timeout got ready=%0b want 1", cfg_ready);
    end
    cfg_valid = 1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_valid = 0;
  endtask

  task automatic pulse_start();
    sweep_start = 1; tick(); sweep_start = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 7;
    if (addr !== 11'd0)     begin errors++; $display("FAIL rst_addr got %0h want 0", addr); end
    if (addr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", addr_valid); end
    if (wrap !== 1'b0)       begin errors++; $display("FAIL rst_wrap got %0b want 0", wrap); end
    if (valid_aligned !== 1'b0) begin errors++; $display("FAIL rst_va got %0b want 0", valid_aligned); end
    if (wrap_aligned !== 1'b0)  begin errors++; $display("FAIL rst_wa got %0b want 0", wrap_aligned); end
    if (sweep_done !== 1'b0)    begin errors++; $display("FAIL rst_done got %0b want 0", sweep_done); end
    if (cfg_ready !== 1'b1)     begin errors++; $display("FAIL rst_ready got %0b want 1", cfg_ready); end
  endtask

  task automatic test_basic();
    apply_reset();
    cfg_valid = 1; cfg_sel = 2'd0; cfg_data = 32'h0020_0000;
    tick();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got %0b want 0", cfg_ready); end
    tick();
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_rise got %0b want 1", cfg_ready); end
    enable = 1;
    for (int i = 0; i <= 2052; i++) begin
      logic [10:0] exp_a;
      exp_a = 11'(i);
      tick();
      checks += 5;
      if (addr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid i=%0d got %0b want 1", i, addr_valid); end
      if (addr !== exp_a) begin errors++; $display("FAIL basic_addr i=%0d got %0h want %0h", i, addr, exp_a); end
      if (wrap !== (i == 2048)) begin errors++; $display("FAIL basic_wrap i=%0d got %0b want %0b", i, wrap, i == 2048); end
      if (valid_aligned !== (i >= 3)) begin errors++; $display("FAIL basic_va i=%0d got %0b want %0b", i, valid_aligned, i >= 3); end
      if (wrap_aligned !== (i == 2051)) begin errors++; $display("FAIL basic_wa i=%0d got %0b want %0b", i, wrap_aligned, i == 2051); end
    end
    enable = 0;
    tick();
    checks += 2;
    if (addr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b want 0", addr_valid); end
    if (addr !== 11'd4) begin errors++; $display("FAIL idle_hold got %0h want 4", addr); end
  endtask

  task automatic test_offset();
    apply_reset();
    cfg_write(2'd0, 32'h0020_0000);
    cfg_write(2'd1, 32'h4000_0000);
    tick();
    enable = 1;
    for (int i = 0; i <= 2050; i++) begin
      logic [10:0] exp_a;
      exp_a = 11'(i + 'h200);
      tick();
      checks += 2;
      if (addr !== exp_a) begin errors++; $display("FAIL off_addr i=%0d got %0h want %0h", i, addr, exp_a); end
      if (wrap !== (i == 2048)) begin errors++; $display("FAIL off_wrap i=%0d got %0b want %0b", i, wrap, i == 2048); end
    end
    enable = 0;
  endtask

  task automatic test_ftw_change();
    apply_reset();
    cfg_write(2'd0, 32'h0020_0000);
    tick();
    enable = 1;
    for (int i = 0; i <= 3075; i++) begin
      logic [10:0] exp_a;
      bit exp_w, exp_r;
      exp_a = (i < 2048) ? 11'(i) : 11'((i - 2048) * 2);
      exp_w = (i == 2048) || (i == 3072);
      exp_r = (i <= 'h100) || (i >= 2047);
      tick();
      checks += 3;
      if (addr !== exp_a) begin errors++; $display("FAIL chg_addr i=%0d got %0h want %0h", i, addr, exp_a); end
      if (wrap !== exp_w) begin errors++; $display("FAIL chg_wrap i=%0d got %0b want %0b", i, wrap, exp_w); end
      if (cfg_ready !== exp_r) begin errors++; $display("FAIL chg_ready i=%0d got %0b want %0b", i, cfg_ready, exp_r); end
      if (i == 'h100) begin cfg_valid = 1; cfg_sel = 2'd0; cfg_data = 32'h0040_0000; end
      if (i == 'h101) cfg_valid = 0;
    end
    enable = 0;
  endtask

  task automatic test_sweep();
    int steps[$];
    int dones = 0;
    logic [10:0] prev, d, last_d;
    apply_reset();
    cfg_write(2'd0, 32'h0020_0000);
    cfg_write(2'd2, 32'h0020_0000);
    cfg_write(2'd3, 32'h0080_0000);
    tick();
    pulse_start();
    enable = 1;
    last_d = 11'd0;
    prev = 11'd0;
    for (int i = 0; i < 3850; i++) begin
      tick();
      checks += 2;
      if (addr !== m_addr) begin errors++; $display("FAIL swp_addr i=%0d got %0h want %0h", i, addr, m_addr); end
      if (sweep_done !== m_done) begin errors++; $display("FAIL swp_done i=%0d got %0b want %0b", i, sweep_done, m_done); end
      if (sweep_done === 1'b1) dones++;
      if (i > 0) begin
        d = addr - prev;
        if (d != last_d) begin steps.push_back(int'(d)); last_d = d; end
      end
      prev = addr;
    end
    enable = 0;
    checks += 2;
    if (steps.size() != 4 || steps[0] != 1 || steps[1] != 2 || steps[2] != 3 || steps[3] != 4) begin
      errors++;
      $display("FAIL swp_steps got n=%0d first=%0d,%0d,%0d,%0d want 1,2,3,4", steps.size(),
               steps.size() > 0 ? steps[0] : -1, steps.size() > 1 ? steps[1] : -1,
               steps.size() > 2 ? steps[2] : -1, steps.size() > 3 ? steps[3] : -1);
    end
    if (dones != 1) begin errors++; $display("FAIL swp_done_count got %0d want 1", dones); end
  endtask

  task automatic test_edges();
    logic [10:0] prev, d;
    int dones, bad;
    apply_reset();
    cfg_write(2'd0, 32'h2000_0000);
    cfg_write(2'd2, 32'h2000_0000);
    cfg_write(2'd3, 32'h8000_0000);
    tick();
    // start and stop together: stop wins, FTW never ramps
    sweep_start = 1; sweep_stop = 1; tick(); sweep_start = 0; sweep_stop = 0;
    enable = 1;
    prev = 11'd0;
    for (int i = 0; i < 40; i++) begin
      tick();
      d = addr - prev;
      if (i > 0) begin
        checks++;
        if (d !== 11'h100) begin errors++; $display("FAIL both_step i=%0d got %0h want 100", i, d); end
      end
      checks++;
      if (sweep_done !== 1'b0) begin errors++; $display("FAIL both_done i=%0d got %0b want 0", i, sweep_done); end
      prev = addr;
    end
    // base >= end: immediate HOLD at ftw_end
    enable = 0;
    cfg_write(2'd3, 32'h4000_0000);
    cfg_write(2'd0, 32'h8000_0000);
    tick();
    pulse_start();
    checks++;
    if (sweep_done !== 1'b1) begin errors++; $display("FAIL ge_done got %0b want 1", sweep_done); end
    tick();
    checks++;
    if (sweep_done !== 1'b0) begin errors++; $display("FAIL ge_done_width got %0b want 0", sweep_done); end
    enable = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      d = addr - prev;
      if (i > 0) begin
        checks++;
        if (d !== 11'h200) begin errors++; $display("FAIL ge_step i=%0d got %0h want 200", i, d); end
      end
      prev = addr;
    end
    // all-ones step saturates at ftw_end
    enable = 0;
    sweep_stop = 1; tick(); sweep_stop = 0;
    cfg_write(2'd0, 32'h2000_0000);
    cfg_write(2'd3, 32'h6000_0000);
    cfg_write(2'd2, 32'hFFFF_FFFF);
    tick();
    pulse_start();
    enable = 1;
    dones = 0; bad = 0; d = 11'd0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i > 0) begin
        d = addr - prev;
        if (d != 11'h100 && d != 11'h300) bad++;
      end
      if (sweep_done === 1'b1) dones++;
      prev = addr;
    end
    enable = 0;
    checks += 3;
    if (bad != 0) begin errors++; $display("FAIL sat_steps got %0d odd steps want 0", bad); end
    if (dones != 1) begin errors++; $display("FAIL sat_done_count got %0d want 1", dones); end
    if (d !== 11'h300) begin errors++; $display("FAIL sat_final_step got %0h want 300", d); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cfg_write(2'd0, 32'h2000_0000);
    cfg_write(2'd2, 32'h2000_0000);
    cfg_write(2'd3, 32'h8000_0000);
    tick();
    pulse_start();
    enable = 1;
    repeat (10) tick();
    cfg_valid = 1; cfg_sel = 2'd1; cfg_data = 32'h1234_5678;
    tick();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending got %0b want 0", cfg_ready); end
    rst = 1;
    tick();
    checks += 5;
    if (addr !== 11'd0 || addr_valid !== 1'b0) begin
      errors++; $display("FAIL mid_addr got %0h/%0b want 0/0", addr, addr_valid);
    end
    if (wrap !== 1'b0 || wrap_aligned !== 1'b0) begin
      errors++; $display("FAIL mid_wrap got %0b/%0b want 0/0", wrap, wrap_aligned);
    end
    if (valid_aligned !== 1'b0) begin errors++; $display("FAIL mid_va got %0b want 0", valid_aligned); end
    if (sweep_done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b want 0", sweep_done); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b want 1", cfg_ready); end
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks += 2;
      if (addr !== 11'd0) begin errors++; $display("FAIL mid_run_addr i=%0d got %0h want 0", i, addr); end
      if (addr_valid !== 1'b1) begin errors++; $display("FAIL mid_run_valid i=%0d got %0b want 1", i, addr_valid); end
    end
    enable = 0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      enable      = ($urandom_range(0, 9) < 8);
      cfg_valid   = ($urandom_range(0, 4) == 0);
      cfg_sel     = 2'($urandom_range(0, 3));
      cfg_data    = $urandom();
      sweep_start = ($urandom_range(0, 29) == 0);
      sweep_stop  = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      tick();
      checks += 7;
      if (addr !== m_addr) begin errors++; $display("FAIL rnd_addr i=%0d got %0h want %0h", i, addr, m_addr); end
      if (addr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid i=%0d got %0b want %0b", i, addr_valid, m_valid); end
      if (wrap !== m_wrap) begin errors++; $display("FAIL rnd_wrap i=%0d got %0b want %0b", i, wrap, m_wrap); end
      if (valid_aligned !== m_va) begin errors++; $display("FAIL rnd_va i=%0d got %0b want %0b", i, valid_aligned, m_va); end
      if (wrap_aligned !== m_wa) begin errors++; $display("FAIL rnd_wa i=%0d got %0b want %0b", i, wrap_aligned, m_wa); end
      if (sweep_done !== m_done) begin errors++; $display("FAIL rnd_done i=%0d got %0b want %0b", i, sweep_done, m_done); end
      if (cfg_ready !== !m_pend) begin errors++; $display("FAIL rnd_ready i=%0d got %0b want %0b", i, cfg_ready, !m_pend); end
    end
    enable = 0; cfg_valid = 0; sweep_start = 0; sweep_stop = 0; rst = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_ftw_change();
    test_sweep();
    test_edges();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dds_phase_gen.md
# dds_phase_gen

Phase-accumulator front end for the DDS datapath: integrates a 32-bit frequency tuning word every enabled cycle and drives the 11-bit phase address consumed by the 3-cycle-latency sine lookup. Tuning words, phase offset and linear-sweep parameters are loaded through a valid/ready config port. Loads commit glitch-free at the accumulator wrap. A built-in sweep FSM produces upward chirps. Valid and wrap strobes are also provided delayed to line up with the lookup's output sample.

## Interface
- ACC_W, 32: accumulator and tuning-word width.
- ADDR_W, 11: output phase address width (top bits of the phase).
- LUT_LAT, 3: downstream lookup latency, used for the aligned strobes.

- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted.
- cfg_sel  in  2  target: 0 = base FTW, 1 = phase offset, 2 = sweep step, 3 = sweep end FTW.
- cfg_data  in  ACC_W  write data.
- enable  in  1  accumulator advances while high.
- sweep_start  in  1  single-cycle pulse: begin sweep.
- sweep_stop  in  1  single-cycle pulse: abort sweep.
- addr  out  ADDR_W  phase address to lookup.
- addr_valid  out  1  addr is a live sample.
- wrap  out  1  first sample after accumulator overflow.
- valid_aligned  out  1  addr_valid delayed LUT_LAT cycles.
- wrap_aligned  out  1  wrap delayed LUT_LAT cycles.
- sweep_done  out  1  one-cycle pulse when sweep reaches end FTW.

## Operation
- Registers:
  - active: ftw_base, phase_off, sweep_step, ftw_end.
  - one shadow data register plus shadow select.
  - ftw_cur: the FTW actually integrated.
  - acc (ACC_W).
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. Data and select go to shadow; pending is set.
  - cfg_ready = !pending.
  - Commit (shadow to active, pending cleared) occurs on a cycle where the acc addition carries out, or on any cycle with enable=0.
- Accumulator, when enable=1: acc <= acc + ftw_cur mod 2^ACC_W, carry captured. When enable=0, acc holds.
- Address: on an enabled cycle, addr <= (acc + phase_off)[ACC_W-1 -: ADDR_W] using pre-increment acc, and addr_valid <= 1. When enable=0, addr_valid <= 0 and addr holds.
- wrap asserts with addr_valid on the sample computed from the first post-overflow acc value, i.e. the carry delayed 2 cycles.
- Sweep FSM, states IDLE, SWEEP, HOLD:
  - IDLE: ftw_cur tracks ftw_base, updated the cycle after a base commit.
  - IDLE/HOLD + sweep_start:
    - ftw_cur <= ftw_base, go to SWEEP.
    - If ftw_base >= ftw_end: ftw_cur <= ftw_end, go to HOLD, and pulse sweep_done.
  - SWEEP, on each carry: ftw_cur <= min(ftw_cur + sweep_step, ftw_end). The sum is computed at ACC_W+1 bits and saturates, with no wrap-around.
  - SWEEP, on reaching ftw_end: go to HOLD and pulse sweep_done.
  - HOLD: ftw_cur frozen at ftw_end.
  - sweep_stop in any state: go to IDLE, ftw_cur <= ftw_base.
- Simultaneous events:
  - sweep_stop and sweep_start in the same cycle: stop wins.
  - Commit and sweep increment on the same carry: the increment uses pre-commit sweep_step/ftw_end, and the new values apply from the next carry.
  - sweep_start while a commit is pending: start uses the current active ftw_base.

## Timing
- Reset values:
  - acc = 0, ftw_cur = 0, all active and shadow registers = 0.
  - pending = 0, so cfg_ready = 1.
  - State IDLE.
  - addr = 0; addr_valid, wrap, valid_aligned, wrap_aligned and sweep_done all 0.
  - Delay pipes cleared.
- Reset mid-operation: all of the above in the next cycle. Any pending config is discarded.
- Latency:
  - enable high at cycle n gives addr_valid at n+1.
  - valid_aligned/wrap_aligned follow addr_valid/wrap by exactly LUT_LAT cycles, so they coincide with the lookup output.
- Config: cfg_ready drops the cycle after acceptance and rises the cycle after commit. When enable=0, the commit happens the cycle after acceptance.
- A new FTW takes effect on the accumulator the cycle after commit (commit cycle +1). The period in progress completes at the old frequency.
- sweep_done is exactly one cycle wide and occurs the cycle the FSM enters HOLD.

## Test plan
- Reset, write sel0 = 0x0020_0000 (enable=0), then enable=1:
  - addr = 0,1,2,… incrementing by 1 per cycle.
  - wrap on the sample addr=0 after 0x7FF.
  - valid_aligned rises 3 cycles after addr_valid.
- Phase offset: sel1 = 0x4000_0000 with FTW 0x0020_0000 → first addr 0x200. The wrap position is unchanged (offset does not affect carry).
- Mid-period FTW change: while running at 0x0020_0000, write 0x0040_0000 at addr≈0x100.
  - cfg_ready stays low until the wrap.
  - Step stays 1 up to 0x7FF, then 2 per cycle after the wrap.
- Sweep: base 0x0020_0000, step 0x0020_0000, end 0x0080_0000, then sweep_start.
  - Steps of 1, 2, 3, then 4 after successive wraps.
  - sweep_done pulses once on entering HOLD; FTW stays 0x0080_0000.
- Edge cases:
  - sweep_start and sweep_stop in the same cycle: FSM stays IDLE.
  - base ≥ end at start: immediate HOLD plus sweep_done.
  - step 0xFFFF_FFFF: saturates at end, no wrap.
- Reset asserted mid-sweep with a pending config:
  - Next cycle all outputs 0, cfg_ready=1.
  - After re-enable, addr stays 0 (ftw_cur=0).
